// File: rtl/sdiv_pkg.sv
// Shared definitions for the sequential signed restoring divider:
// FSM state encoding and the counter-width helper.
package sdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2w(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdiv_negate.sv
// Conditional two's-complement negation, purely combinational.
module sdiv_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/sdiv_restoring.sv
// Sequential signed restoring divider with Start/Busy/Done handshake.
// Define SDIV_REM_EN to add the signed remainder output Rem.
module sdiv_restoring
  import sdiv_pkg::*;
#(
  parameter int DEND_W = 8,
  parameter int DSOR_W = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic signed [DEND_W-1:0] Dend,
  input  logic signed [DSOR_W-1:0] Dsor,
  output logic signed [DEND_W-1:0] Quo,
`ifdef SDIV_REM_EN
  output logic signed [DSOR_W-1:0] Rem,
`endif
  output logic                     Err,
  output logic                     Busy,
  output logic                     Done
);

  localparam int CNT_W = clog2w(DEND_W + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DEND_W);
  localparam logic [DEND_W-1:0] Q_MIN    = {1'b1, {(DEND_W-1){1'b0}}};
  localparam logic [DEND_W-1:0] Q_MAX    = ~Q_MIN;

  state_t state_q, state_d;
  logic   accept, do_load, do_div, do_fix;

  logic [DEND_W-1:0] dend_r, q_q, dend_abs, quo_fixed;
  logic [DSOR_W-1:0] dsor_r, dsor_abs_q, dsor_abs;
  logic [DSOR_W:0]   pr_q;
  logic [DSOR_W+1:0] pr_sh, pr_diff;
  logic [CNT_W-1:0]  cnt_q;
  logic              s_dend_q, s_dsor_q, zero_q, ovf;

  sdiv_negate #(.W(DEND_W)) u_abs_dend (.din(dend_r), .neg(dend_r[DEND_W-1]), .dout(dend_abs));
  sdiv_negate #(.W(DSOR_W)) u_abs_dsor (.din(dsor_r), .neg(dsor_r[DSOR_W-1]), .dout(dsor_abs));
  sdiv_negate #(.W(DEND_W)) u_quo_fix  (.din(q_q), .neg(s_dend_q ^ s_dsor_q), .dout(quo_fixed));

`ifdef SDIV_REM_EN
  logic [DSOR_W-1:0] rem_fixed;
  sdiv_negate #(.W(DSOR_W)) u_rem_fix  (.din(pr_q[DSOR_W-1:0]), .neg(s_dend_q), .dout(rem_fixed));
`endif

  // Shift {PR,Q} left one bit and trial-subtract; the difference MSB is the borrow.
  assign pr_sh   = {pr_q, q_q[DEND_W-1]};
  assign pr_diff = pr_sh - {2'b00, dsor_abs_q};
  assign ovf     = (dend_r == Q_MIN) && (dsor_r == '1);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: defaults at the top of every combinational block keep each signal
  // assigned on all paths, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start) state_d = S_LOAD;
      S_LOAD: state_d = (dsor_r == '0) ? S_FIX : S_DIV;
      S_DIV:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    do_load = 1'b0;
    do_div  = 1'b0;
    do_fix  = 1'b0;
    unique case (state_q)
      S_IDLE: accept  = Start;
      S_LOAD: do_load = 1'b1;
      S_DIV:  do_div  = 1'b1;
      S_FIX:  do_fix  = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dend_r     <= '0;
      dsor_r     <= '0;
      q_q        <= '0;
      dsor_abs_q <= '0;
      pr_q       <= '0;
      cnt_q      <= '0;
      s_dend_q   <= 1'b0;
      s_dsor_q   <= 1'b0;
      zero_q     <= 1'b0;
      Quo        <= '0;
`ifdef SDIV_REM_EN
      Rem        <= '0;
`endif
      Err        <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= do_fix;
      if (accept) begin
        dend_r <= Dend;
        dsor_r <= Dsor;
        Busy   <= 1'b1;
      end
      if (do_load) begin
        q_q        <= dend_abs;
        dsor_abs_q <= dsor_abs;
        s_dend_q   <= dend_r[DEND_W-1];
        s_dsor_q   <= dsor_r[DSOR_W-1];
        pr_q       <= '0;
        cnt_q      <= CNT_INIT;
        zero_q     <= (dsor_r == '0);
      end
      if (do_div) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (!pr_diff[DSOR_W+1]) begin
          pr_q <= pr_diff[DSOR_W:0];
          q_q  <= {q_q[DEND_W-2:0], 1'b1};
        end else begin
          pr_q <= pr_sh[DSOR_W:0];
          q_q  <= {q_q[DEND_W-2:0], 1'b0};
        end
      end
      if (do_fix) begin
        Busy <= 1'b0;
        Err  <= zero_q || ovf;
        // A zero divisor saturates toward the dividend's sign.
        Quo  <= zero_q ? (s_dend_q ? Q_MIN : Q_MAX) : quo_fixed;
`ifdef SDIV_REM_EN
        Rem  <= zero_q ? '0 : rem_fixed;
`endif
      end
    end
  end

endmodule
